// File: rtl/ecc_scalar_mult_ctrl.sv
// rtl/ecc_scalar_mult_ctrl.sv - left-to-right double-and-add sequencer for Q = k*P over GF(2^7)
// Define ECC_SM_CONST_TIME_EN to issue a unit operation on every step regardless of data.
module ecc_scalar_mult_ctrl #(
  parameter int M      = 7,
  parameter int K_W    = 7,
  parameter int OP_LAT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K_W-1:0] scalar,
  input  logic [2*M-1:0] base,
  output logic [2*M-1:0] dbl_point,
  output logic           dbl_load,
  input  logic [2*M-1:0] dbl_sum,
  output logic [2*M-1:0] add_p,
  output logic [2*M-1:0] add_q,
  output logic           add_load,
  input  logic [2*M-1:0] add_sum,
  output logic [2*M-1:0] result,
  output logic           result_inf,
  output logic           busy,
  output logic           done
);

  localparam int PW = 2 * M;
  localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int CW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;
  localparam logic [IW-1:0] I_TOP  = IW'(K_W - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OP_LAT - 1);

  typedef enum logic [2:0] {IDLE, DBL, DBL_WAIT, ADD, ADD_WAIT, DONE} state_t;

  state_t          state;
  logic [K_W-1:0]  k_r;
  logic [PW-1:0]   p_r;
  logic [PW-1:0]   a_pt;
  logic            a_inf;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            use_dbl;
  logic            keep;

  logic            dbl_skip;
  logic            bit_set;
  logic [PW-1:0]   sc_pt;
  logic            sc_inf;
  logic            issue_dbl;
  logic            issue_add;

  assign dbl_skip = a_inf || (a_pt[M-1:0] == '0);
  assign bit_set  = k_r[idx];

  // Short-circuit outcome of the add step, plus which unit (if any) must run instead.
  always_comb begin
    sc_pt     = a_pt;
    sc_inf    = a_inf;
    issue_dbl = 1'b0;
    issue_add = 1'b0;
    if (bit_set) begin
      if (a_inf) begin
        sc_pt  = p_r;
        sc_inf = 1'b0;
      end else if (a_pt == p_r) begin
        if (p_r[M-1:0] == '0) begin
          sc_pt  = '0;
          sc_inf = 1'b1;
        end else begin
          issue_dbl = 1'b1;
        end
      end else if (a_pt[M-1:0] == p_r[M-1:0]) begin
        sc_pt  = '0;
        sc_inf = 1'b1;
      end else begin
        issue_add = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k_r        <= '0;
      p_r        <= '0;
      a_pt       <= '0;
      a_inf      <= 1'b1;
      idx        <= I_TOP;
      cnt        <= '0;
      use_dbl    <= 1'b0;
      keep       <= 1'b0;
      dbl_point  <= '0;
      dbl_load   <= 1'b0;
      add_p      <= '0;
      add_q      <= '0;
      add_load   <= 1'b0;
      result     <= '0;
      result_inf <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      dbl_load <= 1'b0;
      add_load <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            k_r   <= scalar;
            p_r   <= base;
            a_pt  <= '0;
            a_inf <= 1'b1;
            idx   <= I_TOP;
            busy  <= 1'b1;
            state <= DBL;
          end
        end
        DBL: begin
`ifdef ECC_SM_CONST_TIME_EN
          dbl_point <= a_pt;
          dbl_load  <= 1'b1;
          use_dbl   <= 1'b1;
          keep      <= !dbl_skip;
          cnt       <= '0;
          state     <= DBL_WAIT;
          if (dbl_skip) begin
            a_pt  <= '0;
            a_inf <= 1'b1;
          end
`else
          if (dbl_skip) begin
            a_pt  <= '0;
            a_inf <= 1'b1;
            state <= ADD;
          end else begin
            dbl_point <= a_pt;
            dbl_load  <= 1'b1;
            use_dbl   <= 1'b1;
            keep      <= 1'b1;
            cnt       <= '0;
            state     <= DBL_WAIT;
          end
`endif
        end
        ADD: begin
`ifdef ECC_SM_CONST_TIME_EN
          // A takes its short-circuit value now; the unit result only lands if keep is set.
          a_pt  <= sc_pt;
          a_inf <= sc_inf;
          keep  <= issue_dbl | issue_add;
          cnt   <= '0;
          state <= ADD_WAIT;
          if (issue_dbl) begin
            dbl_point <= p_r;
            dbl_load  <= 1'b1;
            use_dbl   <= 1'b1;
          end else begin
            add_p    <= a_pt;
            add_q    <= p_r;
            add_load <= 1'b1;
            use_dbl  <= 1'b0;
          end
`else
          if (issue_dbl) begin
            dbl_point <= p_r;
            dbl_load  <= 1'b1;
            use_dbl   <= 1'b1;
            keep      <= 1'b1;
            cnt       <= '0;
            state     <= ADD_WAIT;
          end else if (issue_add) begin
            add_p    <= a_pt;
            add_q    <= p_r;
            add_load <= 1'b1;
            use_dbl  <= 1'b0;
            keep     <= 1'b1;
            cnt      <= '0;
            state    <= ADD_WAIT;
          end else begin
            a_pt  <= sc_pt;
            a_inf <= sc_inf;
            if (idx == '0) begin
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= DBL;
            end
          end
`endif
        end
        DBL_WAIT, ADD_WAIT: begin
          if (cnt == C_LAST) begin
            if (keep) begin
              a_pt  <= use_dbl ? dbl_sum : add_sum;
              a_inf <= 1'b0;
            end
            if (state == DBL_WAIT) begin
              state <= ADD;
            end else if (idx == '0) begin
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= DBL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          result     <= a_pt;
          result_inf <= a_inf;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
